// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, LSU state type and lane/alignment helpers
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_t;
  function automatic logic [7:0] lane_be(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
    return m[7:0];
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off, input int data_w);
    return ((off & ((3'd1 << size) - 3'd1)) != 3'd0) || (size == SZ_D && data_w == 32);
  endfunction
endpackage

// File: rtl/mem_lane_ext.sv
// mem_lane_ext: shifts the addressed bytes of a bus word down and sign/zero-extends them
module mem_lane_ext
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] ext_o
);
  logic [DATA_W-1:0] sh, keep;
  logic sgn;
  // keep the low 8<<size bits of the shifted word, fill the rest with the sign
  always_comb begin
    sh = data_i >> {off_i, 3'b000};
    keep = ~({DATA_W{1'b1}} << (7'd8 << size_i));
    sgn = ~unsigned_i & (size_i == SZ_B ? sh[7] : size_i == SZ_H ? sh[15] : size_i == SZ_W ? sh[31] : sh[DATA_W-1]);
    ext_o = (sh & keep) | ({DATA_W{sgn}} & ~keep);
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store bus master for the MEM stage with alignment, timeout and flush handling
module mem_lsu
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int LANES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(LANES),
  localparam int CNT_W  = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              exc_bus,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LANES-1:0]  bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata
);
  lsu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic kill_q, kill_d, exc_bus_q, exc_bus_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, ext, wrep, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LANES-1:0] be_q;
  logic [OFF_W-1:0] off, off_q;
  logic [1:0] size_q;
  logic we_q, uns_q, mis, idle_req, accept, busy, tmo, kill_now;
  assign off = in_addr[OFF_W-1:0];
  assign mis = misaligned(in_size, 3'(off), DATA_W);
  assign idle_req = ~reset & state_q == IDLE & in_valid & ~flush;
  assign accept = idle_req & ~mis;
  assign busy = state_q == BUSY;
  assign tmo = cnt_q == CNT_W'(TIMEOUT - 1);
  assign kill_now = kill_q | flush;
  assign stall = accept | busy;
  assign done = state_q == RESP;
  assign rdata = rdata_q;
  assign exc_bus = exc_bus_q;
  assign exc_adel = idle_req & mis & ~in_we;
  assign exc_ades = idle_req & mis & in_we;
  assign bus_req = busy;
  assign bus_we = busy & we_q;
  assign bus_addr = addr_q;
  assign bus_be = be_q;
  assign bus_wdata = wdata_q;
  for (genvar g = 0; g < LANES; g++) begin : g_rep
    assign wrep[8*g +: 8] = in_size == SZ_B ? in_wdata[7:0] : in_size == SZ_H ? in_wdata[8*(g%2) +: 8] :
                            in_size == SZ_W ? in_wdata[8*(g%4) +: 8] : in_wdata[8*g +: 8];
  end
  mem_lane_ext #(.DATA_W(DATA_W)) u_ext (
    .data_i(bus_rdata),
    .off_i(off_q),
    .size_i(size_q),
    .unsigned_i(uns_q),
    .ext_o(ext)
  );
  // latch the accepted request so the bus sees stable values until ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
    end else if (accept) begin
      addr_q <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      be_q <= LANES'(lane_be(in_size, 3'(off)));
      wdata_q <= wrep;
      we_q <= in_we;
      uns_q <= in_unsigned;
      size_q <= in_size;
      off_q <= off;
    end
  end
  // FSM, timeout counter, kill flag and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      kill_q <= 1'b0;
      exc_bus_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      kill_q <= kill_d;
      exc_bus_q <= exc_bus_d;
      rdata_q <= rdata_d;
    end
  end
  // next state: a killed access skips RESP so no done or exc_bus reaches the pipeline
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    kill_d = kill_q;
    exc_bus_d = exc_bus_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = BUSY;
        cnt_d = '0;
        kill_d = 1'b0;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        kill_d = kill_now;
        if (bus_ack | tmo) begin
          state_d = kill_now ? IDLE : RESP;
          kill_d = 1'b0;
          exc_bus_d = ~kill_now & (~bus_ack | bus_err);
          rdata_d = (kill_now | we_q | ~bus_ack) ? '0 : ext;
        end
      end
      RESP: begin
        state_d = IDLE;
        exc_bus_d = 1'b0;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of 32-bit (TIMEOUT=4) and 64-bit (TIMEOUT=16) LSU instances
module tb_mem_lsu;
  logic clk, reset, in_valid, in_we, in_unsigned, flush, bus_ack, bus_err, sel;
  logic [1:0] in_size;
  logic [31:0] in_addr;
  logic [63:0] in_wdata, bus_rdata;
  logic s32, d32, adel32, ades32, ebus32, req32, we32;
  logic [31:0] r32, addr32, wd32;
  logic [3:0] be32;
  logic s64, d64, adel64, ades64, ebus64, req64, we64;
  logic [63:0] r64, wd64;
  logic [31:0] addr64;
  logic [7:0] be64;
  int total = 0, bad = 0;
  mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata[31:0]), .flush(flush),
    .stall(s32), .done(d32), .rdata(r32), .exc_adel(adel32), .exc_ades(ades32), .exc_bus(ebus32),
    .bus_req(req32), .bus_we(we32), .bus_addr(addr32), .bus_be(be32), .bus_wdata(wd32),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata[31:0])
  );
  mem_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .stall(s64), .done(d64), .rdata(r64), .exc_adel(adel64), .exc_ades(ades64), .exc_bus(ebus64),
    .bus_req(req64), .bus_we(we64), .bus_addr(addr64), .bus_be(be64), .bus_wdata(wd64),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );
  logic s_m, d_m, e_m, rq_m, we_m;
  logic [7:0] be_m;
  logic [31:0] a_m;
  logic [63:0] wd_m, r_m;
  assign s_m = sel ? s64 : s32;
  assign d_m = sel ? d64 : d32;
  assign e_m = sel ? ebus64 : ebus32;
  assign rq_m = sel ? req64 : req32;
  assign we_m = sel ? we64 : we32;
  assign be_m = sel ? be64 : {4'h0, be32};
  assign a_m = sel ? addr64 : addr32;
  assign wd_m = sel ? wd64 : {32'h0, wd32};
  assign r_m = sel ? r64 : {32'h0, r32};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic go;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [63:0] wd);
    in_valid = 1'b1;
    in_we = we;
    in_size = size;
    in_unsigned = uns;
    in_addr = addr;
    in_wdata = wd;
  endtask
  task automatic access(input logic s, input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [63:0] rd, input logic [31:0] ea, input logic [7:0] ebe,
                        input logic [63:0] ewd, input logic [63:0] erd, input string tag);
    go;
    sel = s;
    issue(we, size, uns, addr, wd);
    @(negedge clk);
    chk({tag, "_acc"}, {s_m, rq_m}, 2'b10);
    go;
    in_valid = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = rd;
    @(negedge clk);
    chk({tag, "_addr"}, a_m, ea);
    chk({tag, "_be"}, be_m, ebe);
    chk({tag, "_wdata"}, wd_m, ewd);
    chk({tag, "_busy"}, {rq_m, we_m, s_m, d_m}, {1'b1, we, 2'b10});
    go;
    bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, {d_m, s_m, e_m}, 3'b100);
    chk({tag, "_rdata"}, r_m, erd);
  endtask
  initial begin
    clk = 0; reset = 1; sel = 0; flush = 0; bus_ack = 0; bus_err = 0; bus_rdata = '0;
    in_valid = 0; in_we = 0; in_size = 0; in_unsigned = 0; in_addr = '0; in_wdata = '0;
    #12;
    chk("rst_ctl", {s32, d32, req32, we32, adel32, ades32, ebus32, s64, d64, req64}, 0);
    chk("rst_bus", {addr32, be32, wd32}, 0);
    chk("rst_rdata", {r32, r64}, 0);
    go;
    reset = 0;
    access(0, 1, 2, 0, 32'h1004, 64'hDEADBEEF, 0, 32'h1004, 8'h0F, 64'hDEADBEEF, 0, "sw32");
    access(0, 0, 0, 0, 32'h2003, 0, 64'h80FF0000, 32'h2000, 8'h08, 0, 64'hFFFFFF80, "lb32");
    access(0, 0, 0, 1, 32'h2003, 0, 64'h80FF0000, 32'h2000, 8'h08, 0, 64'h00000080, "lbu32");
    access(0, 0, 1, 0, 32'h2002, 0, 64'h80FF0000, 32'h2000, 8'h0C, 0, 64'hFFFF80FF, "lh32");
    access(0, 0, 1, 1, 32'h2002, 0, 64'h80FF0000, 32'h2000, 8'h0C, 0, 64'h000080FF, "lhu32");
    access(1, 1, 1, 0, 32'h1006, 64'h1234, 0, 32'h1000, 8'hC0, 64'h1234123412341234, 0, "sh64");
    access(1, 1, 0, 0, 32'h1005, 64'hAB, 0, 32'h1000, 8'h20, 64'hABABABABABABABAB, 0, "sb64");
    access(1, 0, 2, 0, 32'h1004, 0, 64'h8765432100000000, 32'h1000, 8'hF0, 0, 64'hFFFFFFFF87654321, "lw64");
    access(1, 0, 2, 1, 32'h1004, 0, 64'h8765432100000000, 32'h1000, 8'hF0, 0, 64'h0000000087654321, "lwu64");
    access(1, 0, 3, 0, 32'h1008, 0, 64'h8000000000000001, 32'h1008, 8'hFF, 0, 64'h8000000000000001, "ld64");
    go;
    issue(0, 3, 0, 32'h1004, 0);
    @(negedge clk);
    chk("ld64_adel", {adel64, ades64, s64}, 3'b100);
    go;
    in_valid = 0;
    @(negedge clk);
    chk("ld64_noreq", {req64, s64}, 0);
    go;
    issue(1, 2, 0, 32'h1002, 64'h77);
    @(negedge clk);
    chk("sw32_ades", {adel32, ades32, s32}, 3'b010);
    go;
    in_valid = 0;
    @(negedge clk);
    chk("sw32_noreq", req32, 0);
    go;
    issue(1, 2, 0, 32'h1000, 64'h99);
    flush = 1;
    @(negedge clk);
    chk("flush_acc", {s32, ades32, adel32}, 0);
    go;
    in_valid = 0;
    flush = 0;
    @(negedge clk);
    chk("flush_noreq", {req32, req64}, 0);
    go;
    issue(0, 2, 0, 32'h3000, 0);
    @(negedge clk);
    chk("to_acc", s32, 1);
    for (int i = 0; i < 4; i++) begin
      go;
      in_valid = 0;
      @(negedge clk);
      chk("to_req", {req32, s32, d32}, 3'b110);
    end
    go;
    @(negedge clk);
    chk("to_done", {d32, ebus32, s32, req32}, 4'b1100);
    go;
    bus_ack = 1;
    bus_err = 1;
    @(negedge clk);
    chk("ign_idle", {req32, req64}, 2'b01);
    go;
    bus_ack = 0;
    bus_err = 0;
    @(negedge clk);
    chk("ack_ign32", {d32, ebus32, s32}, 0);
    chk("err64", {d64, ebus64, s64}, 3'b110);
    go;
    issue(0, 2, 0, 32'h3004, 0);
    for (int i = 0; i < 3; i++) begin
      go;
      in_valid = 0;
      @(negedge clk);
      chk("late_req", req32, 1);
    end
    go;
    bus_ack = 1;
    bus_rdata = 64'h11223344;
    @(negedge clk);
    chk("late_ackcyc", {req32, s32}, 2'b11);
    go;
    bus_ack = 0;
    @(negedge clk);
    chk("late_done", {d32, ebus32}, 2'b10);
    chk("late_rdata", r32, 32'h11223344);
    go;
    issue(1, 2, 0, 32'h1000, 64'h55);
    go;
    in_valid = 0;
    go;
    flush = 1;
    @(negedge clk);
    chk("kill_b2", {req64, s64}, 2'b11);
    go;
    flush = 0;
    go;
    go;
    bus_ack = 1;
    @(negedge clk);
    chk("kill_ack", {req64, s64}, 2'b11);
    go;
    bus_ack = 0;
    @(negedge clk);
    chk("kill_after", {req64, s64, d64, ebus64}, 0);
    chk("kill32", {d32, ebus32, req32}, 0);
    go;
    @(negedge clk);
    chk("kill_nodone", {d64, ebus64}, 0);
    go;
    issue(0, 2, 0, 32'h1008, 0);
    go;
    in_valid = 0;
    @(negedge clk);
    chk("rst_busy", {req32, s32}, 2'b11);
    #1 reset = 1;
    #1 chk("rst_async", {req32, s32, req64, s64}, 0);
    #1 reset = 0;
    access(0, 0, 2, 0, 32'h1008, 0, 64'hCAFEF00D, 32'h1008, 8'h0F, 0, 64'hCAFEF00D, "lw32_post");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
